// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the UART
// transmitter. The arbiter connects through the master modport; the
// environment (producers plus transmitter) uses the slave modport.
`timescale 1ns / 1ps

interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               txd_done;
    logic               busy;
    logic               timeout_err;

    modport master (
        input  req, req_data, txd_done,
        output grant, tx_data, tx_start, busy, timeout_err
    );

    modport slave (
        output req, req_data, txd_done,
        input  grant, tx_data, tx_start, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// producers. One frame in flight at a time; tx_data is frozen from launch
// until the next selection; optional idle gap after each frame.
// Optional watchdog in WAIT_DONE is enabled by defining UART_ARB_TIMEOUT_EN.
`timescale 1ns / 1ps

module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int PW = $clog2(N_REQ);
    localparam int IW = PW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [IW-1:0] N_WIDE   = IW'(N_REQ);

    // Reject configurations outside the supported range at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    logic [PW-1:0]     win_sel;
    logic [IW-1:0]     idx;
    logic [N_REQ-1:0]  grant_d;
    logic              req_any;
    logic              timeout_hit;
    logic [GW-1:0]     gap_cnt_q;
    logic [N_REQ-1:0]  grant_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;

    assign req_any = |bus.req;

    // Round-robin search: walk offsets from the far end back toward ptr so
    // the requester closest to ptr (wrapping) is the one left selected.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_sel = ptr_q;
        idx     = '0;
        grant_d = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + IW'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (bus.req[idx[PW-1:0]]) begin
                win_sel = idx[PW-1:0];
            end
        end
        grant_d[win_sel] = 1'b1;
    end

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests only matter in IDLE, completion only in WAIT_DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.txd_done || timeout_hit) begin
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs, winner capture, round-robin pointer and gap counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            win_q      <= '0;
            ptr_q      <= '0;
            gap_cnt_q  <= '0;
        end else begin
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= (state_d != S_IDLE);

            if (state_q == S_IDLE && req_any) begin
                grant_q    <= grant_d;
                tx_start_q <= 1'b1;
                tx_data_q  <= bus.req_data[{win_sel, 3'b000} +: 8];
                win_q      <= win_sel;
            end

            if (state_q == S_LAUNCH) begin
                ptr_q <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end

            if (state_q == S_WAIT_DONE && state_d == S_GAP) begin
                gap_cnt_q <= GAP_LOAD;
            end else if (state_q == S_GAP) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] wd_cnt_q;
    logic        timeout_err_q;

    // A completion pulse landing on the limit cycle wins over the watchdog.
    assign timeout_hit = (state_q == S_WAIT_DONE) && !bus.txd_done && (wd_cnt_q == TO_LAST);

    // Watchdog counts cycles spent in WAIT_DONE, restarted by every launch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_hit;
            if (state_q == S_LAUNCH) begin
                wd_cnt_q <= '0;
            end else if (state_q == S_WAIT_DONE) begin
                wd_cnt_q <= wd_cnt_q + 24'd1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;

endmodule
